banked_reg_file: RTL and testbench
==================================

// Module: banked_reg_file
// PURPOSE
//  Multi-bank register file for the 8-bit core; successor of the single-bank regfile.
//  Format-aware operand decode: R, BRANCH and SHIFT formats.
//  Adds NBANK register banks with a 1-cycle bank switch and a multi-cycle background bank copy (context save).
//  Sits between Ctrl/decode and the ALU; the write port is fed from writeback.
// PARAMETERS
//  W      8  data width
//  A      3  full register address width; 2**A regs per bank
//  SA     2  short address width used by BRANCH/SHIFT formats (SA<=A)
//  NBANK  2  number of banks (>=2); BW=$clog2(NBANK)
// PORTS
//  Clk        in   1      clock
//  Reset      in   1      synchronous, active-high reset
//  Mode       in   2      operand format: 00 R, 01 BRANCH, 10 SHIFT, 11 reserved
//  RaddrA     in   A      R-format read A
//  RaddrB     in   A      R-format read B; SHIFT-format immediate
//  Waddr      in   A      R-format write address
//  ShortA     in   SA     BRANCH/SHIFT operand A, also the write address in those formats
//  ShortB     in   SA     BRANCH operand B
//  WriteEn    in   1      write DataIn this cycle
//  DataIn     in   W      write data
//  DataOutA   out  W      read port A (combinational)
//  DataOutB   out  W      read port B (combinational)
//  SwitchReq  in   1      make BankTgt the active bank
//  CopyReq    in   1      copy active bank -> BankTgt
//  BankTgt    in   BW     target bank for switch/copy
//  ActiveBank out  BW     current active bank (registered)
//  Busy       out  1      copy in progress
//  Done       out  1      1-cycle pulse when a copy completes
//  Err        out  1      1-cycle pulse when a request is rejected
// BEHAVIOUR
//  Reset: all banks all regs=0; ActiveBank=0; Busy/Done/Err=0; copy FSM=IDLE; any copy in progress is aborted.
//  Operand decode (all in the active bank):
//   R      : A=R[RaddrA], B=R[RaddrB], write R[Waddr]
//   BRANCH : A=R[ShortA], B=R[ShortB], write R[ShortA]
//   SHIFT  : A=R[ShortA], B=zero-extended RaddrB (immediate), write R[ShortA]
//   rsvd   : A=B=0; writes ignored
//  ShortA/ShortB are zero-extended to A bits.
//  Write: at posedge when WriteEn && Mode!=rsvd. Visible on reads the next cycle.
//  Switch: accepted when SwitchReq && !Busy && BankTgt<NBANK && !CopyReq.
//   ActiveBank<=BankTgt at the next edge. A same-cycle write goes to the OLD bank.
//  Copy FSM IDLE->COPY->IDLE:
//   Accepted when CopyReq && !Busy && !SwitchReq && BankTgt<NBANK && BankTgt!=ActiveBank.
//   Latches dst and sets ptr=0. Busy=1 from the next cycle.
//   Each COPY cycle: dst[ptr]<=active[ptr]; ptr++.
//   After 2**A cycles: ->IDLE, Busy=0, Done=1 for one cycle. Total Busy duration: 2**A cycles.
//  Write during COPY at index i:
//   always goes to the active bank;
//   also mirrored to dst when i<ptr;
//   when i==ptr, the copy takes the new DataIn.
//   The dst bank is therefore coherent at Done.
//  Err=1 (next cycle, 1 cycle) when:
//   a request arrives while Busy;
//   SwitchReq and CopyReq arrive together (neither is performed);
//   BankTgt>=NBANK;
//   copy dst==ActiveBank.
//  Switch to the already-active bank: legal no-op, no Err.
//  Reads are unaffected by copy activity.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//   a read port whose decoded register equals the decoded write register,
//   with WriteEn && Mode!=rsvd, returns DataIn combinationally in the same cycle.
//   The SHIFT immediate on port B is never bypassed.
//  Not defined: reads return the stored value; the new value appears the next cycle.
// STRUCTURE
//  regfile_pkg:
//   typedef enum logic[1:0] rf_mode_t {RF_R, RF_BRANCH, RF_SHIFT, RF_RSVD};
//   typedef enum logic rf_copy_st_t {CP_IDLE, CP_COPY};
//  Sub-module rf_operand_decode (combinational):
//   Mode + address fields -> rd_a_idx, rd_b_idx, b_is_imm, wr_idx, wr_ok.
//  Storage: logic [W-1:0] regs[NBANK][2**A]; a single always_ff owns all bank writes.
// TESTING
//  1 Reset, then R write R5=0x3C; next cycle R read A=5 -> DataOutA=0x3C; all other regs read 0.
//  2 SHIFT: ShortA=2 holds 0x81, RaddrB=3 -> DataOutA=0x81, DataOutB=0x03; write 0x40 lands in R2.
//  3 R3=0x11 in bank0; CopyReq BankTgt=1 -> Busy 8 cycles, Done pulse; SwitchReq 1 -> R3 reads 0x11.
//  4 During copy, write R0=0xAA when ptr=4 -> after Done and switch, bank1 R0=0xAA.
//  5 SwitchReq during Busy, or CopyReq BankTgt==ActiveBank -> Err pulse; ActiveBank unchanged.
//  6 With REGFILE_BYPASS_EN, write R6=0x5A while reading R6 -> DataOutA=0x5A in the same cycle;
//    without the macro -> old value that cycle, 0x5A the next.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types for the banked register file and its operand decoder.
// Ports: none (package only).
// Holds the operand-format encoding and the background-copy FSM states.
package regfile_pkg;

  // Operand format selected by the decoder's Mode field.
  typedef enum logic [1:0] {
    RF_R      = 2'b00,
    RF_BRANCH = 2'b01,
    RF_SHIFT  = 2'b10,
    RF_RSVD   = 2'b11
  } rf_mode_t;

  // Background bank-copy state machine.
  typedef enum logic {
    CP_IDLE = 1'b0,
    CP_COPY = 1'b1
  } rf_copy_st_t;

endpackage

// File: rtl/rf_operand_decode.sv
// Combinational operand decoder: maps Mode plus the address fields to register indices.
// Ports: mode, raddr_a, raddr_b, waddr, short_a, short_b in; rd_a_idx, rd_b_idx,
//        wr_idx, b_is_imm, rd_ok, wr_ok out. Short fields are zero-extended to A bits.
module rf_operand_decode
  import regfile_pkg::*;
#(
  parameter int A  = 3,
  parameter int SA = 2
) (
  input  logic [1:0]    mode,
  input  logic [A-1:0]  raddr_a,
  input  logic [A-1:0]  raddr_b,
  input  logic [A-1:0]  waddr,
  input  logic [SA-1:0] short_a,
  input  logic [SA-1:0] short_b,
  output logic [A-1:0]  rd_a_idx,
  output logic [A-1:0]  rd_b_idx,
  output logic [A-1:0]  wr_idx,
  output logic          b_is_imm,
  output logic          rd_ok,
  output logic          wr_ok
);

  logic [A-1:0] short_a_x;
  logic [A-1:0] short_b_x;

  assign short_a_x = A'(short_a);
  assign short_b_x = A'(short_b);

  always_comb begin
    rd_a_idx = '0;
    rd_b_idx = '0;
    wr_idx   = '0;
    b_is_imm = 1'b0;
    rd_ok    = 1'b0;
    wr_ok    = 1'b0;
    case (rf_mode_t'(mode))
      RF_R: begin
        rd_a_idx = raddr_a;
        rd_b_idx = raddr_b;
        wr_idx   = waddr;
        rd_ok    = 1'b1;
        wr_ok    = 1'b1;
      end
      RF_BRANCH: begin
        rd_a_idx = short_a_x;
        rd_b_idx = short_b_x;
        wr_idx   = short_a_x;
        rd_ok    = 1'b1;
        wr_ok    = 1'b1;
      end
      RF_SHIFT: begin
        // Port B carries raddr_b as an immediate; rd_b_idx is left unused.
        rd_a_idx = short_a_x;
        wr_idx   = short_a_x;
        b_is_imm = 1'b1;
        rd_ok    = 1'b1;
        wr_ok    = 1'b1;
      end
      default: begin
        // Reserved format: both reads return zero and writes are dropped.
      end
    endcase
  end

endmodule

// File: rtl/banked_reg_file.sv
// Multi-bank register file with format-aware operand decode, 1-cycle bank switch
// and a 2**A-cycle background copy of the active bank into a target bank.
// Ports: Clk, Reset (sync, active-high); Mode/RaddrA/RaddrB/Waddr/ShortA/ShortB operand
//        fields; WriteEn/DataIn write port; DataOutA/DataOutB combinational reads;
//        SwitchReq/CopyReq/BankTgt bank control; ActiveBank/Busy/Done/Err status.
// Optional: define REGFILE_BYPASS_EN to forward same-cycle write data onto read ports.
module banked_reg_file
  import regfile_pkg::*;
#(
  parameter int W     = 8,
  parameter int A     = 3,
  parameter int SA    = 2,
  parameter int NBANK = 2,
  localparam int BW   = $clog2(NBANK),
  localparam int NREG = 2 ** A
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [1:0]    Mode,
  input  logic [A-1:0]  RaddrA,
  input  logic [A-1:0]  RaddrB,
  input  logic [A-1:0]  Waddr,
  input  logic [SA-1:0] ShortA,
  input  logic [SA-1:0] ShortB,
  input  logic          WriteEn,
  input  logic [W-1:0]  DataIn,
  output logic [W-1:0]  DataOutA,
  output logic [W-1:0]  DataOutB,
  input  logic          SwitchReq,
  input  logic          CopyReq,
  input  logic [BW-1:0] BankTgt,
  output logic [BW-1:0] ActiveBank,
  output logic          Busy,
  output logic          Done,
  output logic          Err
);

  logic [W-1:0] regs [NBANK][NREG];

  rf_copy_st_t  cp_st;
  rf_copy_st_t  cp_st_nxt;
  logic [BW-1:0] active;
  logic [BW-1:0] cp_dst;
  logic [A-1:0]  cp_ptr;
  logic          done_q;
  logic          err_q;

  logic [A-1:0]  rd_a_idx;
  logic [A-1:0]  rd_b_idx;
  logic [A-1:0]  wr_idx;
  logic          b_is_imm;
  logic          rd_ok;
  logic          wr_ok;

  logic          busy;
  logic          wr_en;
  logic          tgt_ok;
  logic          sw_acc;
  logic          cp_acc;
  logic          rej;
  logic          copy_last;
  logic [W-1:0]  rd_a_val;
  logic [W-1:0]  rd_b_val;

  rf_operand_decode #(
    .A  (A),
    .SA (SA)
  ) u_dec (
    .mode     (Mode),
    .raddr_a  (RaddrA),
    .raddr_b  (RaddrB),
    .waddr    (Waddr),
    .short_a  (ShortA),
    .short_b  (ShortB),
    .rd_a_idx (rd_a_idx),
    .rd_b_idx (rd_b_idx),
    .wr_idx   (wr_idx),
    .b_is_imm (b_is_imm),
    .rd_ok    (rd_ok),
    .wr_ok    (wr_ok)
  );

  assign busy      = (cp_st == CP_COPY);
  assign wr_en     = WriteEn & wr_ok;
  assign tgt_ok    = (32'(BankTgt) < NBANK);
  assign copy_last = busy & (&cp_ptr);

  // A switch to the already-active bank counts as accepted (harmless no-op),
  // so every request that is neither accepted switch nor accepted copy is an error.
  assign sw_acc = SwitchReq & ~CopyReq & ~busy & tgt_ok;
  assign cp_acc = CopyReq & ~SwitchReq & ~busy & tgt_ok & (BankTgt != active);
  assign rej    = (SwitchReq | CopyReq) & ~sw_acc & ~cp_acc;

  // Copy FSM next state.
  always_comb begin
    cp_st_nxt = cp_st;
    case (cp_st)
      CP_IDLE: if (cp_acc)    cp_st_nxt = CP_COPY;
      CP_COPY: if (copy_last) cp_st_nxt = CP_IDLE;
      default:                cp_st_nxt = CP_IDLE;
    endcase
  end

  // Control state: FSM, pointer, active bank, status pulses.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cp_st  <= CP_IDLE;
      cp_ptr <= '0;
      cp_dst <= '0;
      active <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cp_st  <= cp_st_nxt;
      done_q <= copy_last;
      err_q  <= rej;
      if (sw_acc) begin
        active <= BankTgt;
      end
      if (cp_acc) begin
        cp_dst <= BankTgt;
        cp_ptr <= '0;
      end else if (busy) begin
        cp_ptr <= cp_ptr + A'(1);
      end
    end
  end

  // Sole owner of bank storage. Writes use the current (pre-switch) active bank.
  // During a copy, entries below cp_ptr are already copied, so writes there are
  // mirrored into the destination; a write at cp_ptr replaces the copied value.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int b = 0; b < NBANK; b++) begin
        for (int r = 0; r < NREG; r++) begin
          regs[b][r] <= '0;
        end
      end
    end else begin
      if (busy) begin
        regs[cp_dst][cp_ptr] <= (wr_en && (wr_idx == cp_ptr)) ? DataIn
                                                               : regs[active][cp_ptr];
      end
      if (wr_en) begin
        regs[active][wr_idx] <= DataIn;
        if (busy && (wr_idx < cp_ptr)) begin
          regs[cp_dst][wr_idx] <= DataIn;
        end
      end
    end
  end

  // Read ports.
  always_comb begin
    rd_a_val = regs[active][rd_a_idx];
    rd_b_val = regs[active][rd_b_idx];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (wr_idx == rd_a_idx)) begin
      rd_a_val = DataIn;
    end
    if (wr_en && (wr_idx == rd_b_idx)) begin
      rd_b_val = DataIn;
    end
`endif
    DataOutA = '0;
    DataOutB = '0;
    if (rd_ok) begin
      DataOutA = rd_a_val;
      // The SHIFT immediate bypasses storage and forwarding entirely.
      DataOutB = b_is_imm ? W'(RaddrB) : rd_b_val;
    end
  end

  assign ActiveBank = active;
  assign Busy       = busy;
  assign Done       = done_q;
  assign Err        = err_q;

endmodule

// File: tb/tb_banked_reg_file.sv
module tb_banked_reg_file;

  localparam int W     = 8;
  localparam int A     = 3;
  localparam int SA    = 2;
  localparam int NBANK = 2;
  localparam int BW    = 1;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [1:0]    Mode;
  logic [A-1:0]  RaddrA, RaddrB, Waddr;
  logic [SA-1:0] ShortA, ShortB;
  logic          WriteEn;
  logic [W-1:0]  DataIn;
  logic [W-1:0]  DataOutA, DataOutB;
  logic          SwitchReq, CopyReq;
  logic [BW-1:0] BankTgt;
  logic [BW-1:0] ActiveBank;
  logic          Busy, Done, Err;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  banked_reg_file #(.W(W), .A(A), .SA(SA), .NBANK(NBANK)) dut (
    .Clk(Clk), .Reset(Reset), .Mode(Mode), .RaddrA(RaddrA), .RaddrB(RaddrB),
    .Waddr(Waddr), .ShortA(ShortA), .ShortB(ShortB), .WriteEn(WriteEn),
    .DataIn(DataIn), .DataOutA(DataOutA), .DataOutB(DataOutB),
    .SwitchReq(SwitchReq), .CopyReq(CopyReq), .BankTgt(BankTgt),
    .ActiveBank(ActiveBank), .Busy(Busy), .Done(Done), .Err(Err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_regs [2][8];
  logic       m_active;
  logic       m_dst;
  int         m_cnt;    // remaining copy cycles, 0 when idle
  logic       m_done;
  logic       m_err;

  function automatic logic m_wr();
    return WriteEn && (Mode != 2'b11);
  endfunction

  function automatic logic [2:0] m_widx();
    return (Mode == 2'b00) ? Waddr : {1'b0, ShortA};
  endfunction

  function automatic logic [7:0] exp_a();
    logic [2:0] idx;
    if (Mode == 2'b11) return 8'h00;
    idx = (Mode == 2'b00) ? RaddrA : {1'b0, ShortA};
`ifdef REGFILE_BYPASS_EN
    if (m_wr() && (m_widx() == idx)) return DataIn;
`endif
    return m_regs[m_active][idx];
  endfunction

  function automatic logic [7:0] exp_b();
    logic [2:0] idx;
    if (Mode == 2'b11) return 8'h00;
    if (Mode == 2'b10) return {5'b0, RaddrB};
    idx = (Mode == 2'b00) ? RaddrB : {1'b0, ShortB};
`ifdef REGFILE_BYPASS_EN
    if (m_wr() && (m_widx() == idx)) return DataIn;
`endif
    return m_regs[m_active][idx];
  endfunction

  always @(posedge Clk) begin : model
    logic ok;
    if (Reset) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < 8; r++) m_regs[b][r] = 8'h00;
      m_active = 1'b0;
      m_dst    = 1'b0;
      m_cnt    = 0;
      m_done   = 1'b0;
      m_err    = 1'b0;
    end else begin
      ok     = (int'(BankTgt) < NBANK);
      m_err  = (SwitchReq || CopyReq) &&
               ((m_cnt != 0) || (SwitchReq && CopyReq) || !ok ||
                (CopyReq && (BankTgt == m_active)));
      m_done = 1'b0;
      if (m_wr()) m_regs[m_active][m_widx()] = DataIn;
      if (m_cnt != 0) begin
        m_cnt--;
        // The destination must equal the source bank when the copy finishes.
        if (m_cnt == 0) begin
          for (int r = 0; r < 8; r++) m_regs[m_dst][r] = m_regs[m_active][r];
          m_done = 1'b1;
        end
      end else if (SwitchReq && !CopyReq && ok) begin
        m_active = BankTgt;
      end else if (CopyReq && !SwitchReq && ok && (BankTgt != m_active)) begin
        m_cnt = 8;
        m_dst = BankTgt;
      end
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("cyc_dout_a", 32'(DataOutA), 32'(exp_a()));
      chk("cyc_dout_b", 32'(DataOutB), 32'(exp_b()));
      chk("cyc_active", 32'(ActiveBank), 32'(m_active));
      chk("cyc_busy",   32'(Busy), 32'(m_cnt != 0));
      chk("cyc_done",   32'(Done), 32'(m_done));
      chk("cyc_err",    32'(Err),  32'(m_err));
    end
  end

  // ---------------- directed stimulus ----------------
  logic [7:0] b1_exp [8];
  int busy_n, done_n, done_k;
  logic seen;

  task automatic idle();
    WriteEn = 1'b0; SwitchReq = 1'b0; CopyReq = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    b1_exp = '{8'hAA, 8'h00, 8'h40, 8'h11, 8'h00, 8'h3C, 8'h66, 8'h77};
    Reset = 1'b1; Mode = 2'b00; RaddrA = '0; RaddrB = '0; Waddr = '0;
    ShortA = '0; ShortB = '0; DataIn = '0; BankTgt = '0;
    idle();
    step(); step();
    Reset = 1'b0;
    chk_en = 1'b1;
    #3;
    chk("rst_active", 32'(ActiveBank), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_err", 32'(Err), 0);

    // 1: R write R5=0x3C, read back, others zero
    step();
    Waddr = 3'd5; DataIn = 8'h3C; WriteEn = 1'b1;
    step();
    WriteEn = 1'b0; RaddrA = 3'd5;
    #3 chk("t1_r5", 32'(DataOutA), 32'h3C);
    for (int i = 0; i < 8; i++) begin
      step();
      RaddrA = 3'(i);
      #3 chk("t1_reg", 32'(DataOutA), (i == 5) ? 32'h3C : 32'h0);
    end

    // 2: SHIFT format read and write
    step();
    Waddr = 3'd2; DataIn = 8'h81; WriteEn = 1'b1;
    step();
    WriteEn = 1'b0; Mode = 2'b10; ShortA = 2'd2; RaddrB = 3'd3;
    #3;
    chk("t2_shift_a", 32'(DataOutA), 32'h81);
    chk("t2_shift_b", 32'(DataOutB), 32'h03);
    step();
    DataIn = 8'h40; WriteEn = 1'b1;
    step();
    WriteEn = 1'b0; Mode = 2'b00; RaddrA = 3'd2;
    #3 chk("t2_r2", 32'(DataOutA), 32'h40);

    // 3+4: copy bank0 -> bank1 with writes at i>ptr, i<ptr, i==ptr
    step();
    Waddr = 3'd3; DataIn = 8'h11; WriteEn = 1'b1;
    step();
    WriteEn = 1'b0; CopyReq = 1'b1; BankTgt = 1'b1;
    step();
    CopyReq = 1'b0;
    busy_n = 0; done_n = 0; done_k = -1;
    for (int k = 0; k < 12; k++) begin
      WriteEn = 1'b0;
      if (k == 2) begin Waddr = 3'd7; DataIn = 8'h77; WriteEn = 1'b1; end
      if (k == 4) begin Waddr = 3'd0; DataIn = 8'hAA; WriteEn = 1'b1; end
      if (k == 6) begin Waddr = 3'd6; DataIn = 8'h66; WriteEn = 1'b1; end
      #3;
      if (Busy === 1'b1) busy_n++;
      if (Done === 1'b1) begin done_n++; done_k = k; end
      step();
    end
    WriteEn = 1'b0;
    chk("t3_busy_len", 32'(busy_n), 8);
    chk("t3_done_cnt", 32'(done_n), 1);
    chk("t3_done_at",  32'(done_k), 8);
    SwitchReq = 1'b1; BankTgt = 1'b1;
    step();
    SwitchReq = 1'b0;
    #3 chk("t3_active1", 32'(ActiveBank), 1);
    chk("model_b1_r0", 32'(m_regs[1][0]), 32'hAA);
    chk("model_b1_r3", 32'(m_regs[1][3]), 32'h11);
    for (int i = 0; i < 8; i++) begin
      step();
      RaddrA = 3'(i);
      #3 chk("t3_b1_reg", 32'(DataOutA), 32'(b1_exp[i]));
    end

    // 5: rejected requests
    step();
    CopyReq = 1'b1; BankTgt = 1'b1;
    step();
    CopyReq = 1'b0;
    #3;
    chk("t5_cp_self_err", 32'(Err), 1);
    chk("t5_cp_self_busy", 32'(Busy), 0);
    chk("t5_cp_self_act", 32'(ActiveBank), 1);
    step();
    #3 chk("t5_err_pulse", 32'(Err), 0);
    step();
    SwitchReq = 1'b1; CopyReq = 1'b1; BankTgt = 1'b0;
    step();
    idle();
    #3;
    chk("t5_both_err", 32'(Err), 1);
    chk("t5_both_act", 32'(ActiveBank), 1);
    chk("t5_both_busy", 32'(Busy), 0);
    step();
    SwitchReq = 1'b1; BankTgt = 1'b1;
    step();
    idle();
    #3;
    chk("t5_same_sw_err", 32'(Err), 0);
    chk("t5_same_sw_act", 32'(ActiveBank), 1);
    step();
    CopyReq = 1'b1; BankTgt = 1'b0;
    step();
    CopyReq = 1'b0; SwitchReq = 1'b1;
    #3 chk("t5_busy", 32'(Busy), 1);
    step();
    SwitchReq = 1'b0;
    #3;
    chk("t5_sw_busy_err", 32'(Err), 1);
    chk("t5_sw_busy_act", 32'(ActiveBank), 1);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      #3;
      if (Done === 1'b1) begin seen = 1'b1; break; end
    end
    chk("t5_copy_done", 32'(seen), 1);

    // 6: same-cycle read of a register being written
    step();
    Mode = 2'b00; Waddr = 3'd6; DataIn = 8'h5A; WriteEn = 1'b1; RaddrA = 3'd6;
`ifdef REGFILE_BYPASS_EN
    #3 chk("t6_same_cycle", 32'(DataOutA), 32'h5A);
`else
    #3 chk("t6_same_cycle", 32'(DataOutA), 32'h66);
`endif
    step();
    WriteEn = 1'b0;
    #3 chk("t6_next_cycle", 32'(DataOutA), 32'h5A);

    // SHIFT write: immediate on B is never forwarded
    step();
    Mode = 2'b10; ShortA = 2'd1; RaddrB = 3'd1; DataIn = 8'h99; WriteEn = 1'b1;
    #3 chk("t6_shift_imm", 32'(DataOutB), 32'h01);
    // Reserved format: zero outputs, write dropped
    step();
    Mode = 2'b11; Waddr = 3'd1; DataIn = 8'hFF; WriteEn = 1'b1; RaddrA = 3'd1;
    #3;
    chk("t6_rsvd_a", 32'(DataOutA), 0);
    chk("t6_rsvd_b", 32'(DataOutB), 0);
    step();
    WriteEn = 1'b0; Mode = 2'b00;
    #3 chk("t6_r1_after", 32'(DataOutA), 32'h99);

    step(); step();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
